level_pump_controller: RTL and testbench

Supervisory controller for the liquid-level decoder. It samples the decoded level percentage and error flag at a fixed sample rate and filters them with a stability (debounce) check. A hysteresis FSM uses the filtered result to drive the fill pump, with a pump-run timeout and a latched fault state. It sits between the sensor decoder and the pump driver, display and alarm logic.

---
 rtl/level_pump_controller_if.sv | 29 ++
 rtl/level_pump_controller.sv | 211 +++++++++++++++++++++
 tb/tb_level_pump_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/level_pump_controller_if.sv
// Signal bundle between the level supervisor and its sensor/pump/display neighbours.
// The controller connects through the slave modport; the surrounding logic uses master.
interface level_pump_controller_if;
    logic [7:0] level_pct;
    logic       level_error;
    logic       manual_stop;
    logic       fault_clear;

    logic       pump_on;
    logic       alarm_low;
    logic       alarm_high;
    logic       fault;
    logic [1:0] fault_code;
    logic [1:0] state;
    logic [7:0] filtered_level;
    logic       sample_tick;

    modport master (
        output level_pct, level_error, manual_stop, fault_clear,
        input  pump_on, alarm_low, alarm_high, fault, fault_code, state,
               filtered_level, sample_tick
    );

    modport slave (
        input  level_pct, level_error, manual_stop, fault_clear,
        output pump_on, alarm_low, alarm_high, fault, fault_code, state,
               filtered_level, sample_tick
    );
endinterface

// File: rtl/level_pump_controller.sv
// Liquid-level supervisor: periodic sampling, stability filter, hysteresis pump FSM
// with a run timeout and a latched fault that needs an acknowledge on a clean sensor.
//
// state   | meaning
// IDLE    | pump off, waiting for a stable level at or below the low threshold
// FILLING | pump on, run timer counts evals until high level, stop or timeout
// FAULT   | pump off, latched until fault_clear arrives with the sensor healthy
module level_pump_controller #(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 4,
    parameter int ERR_SAMPLES    = 3,
    parameter int LOW_THRESH     = 25,
    parameter int HIGH_THRESH    = 88,
    parameter int PUMP_TIMEOUT   = 30000
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    level_pump_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FILLING = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;

    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = $clog2(STABLE_SAMPLES + 1);
    localparam int EW = $clog2(ERR_SAMPLES + 1);
    localparam int RW = $clog2(PUMP_TIMEOUT + 1);

    localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] STB_MAX  = SW'(STABLE_SAMPLES);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_SAMPLES);
    localparam logic [RW-1:0] RUN_LAST = RW'(PUMP_TIMEOUT - 1);
    localparam logic [7:0]    LOW_LVL  = 8'(LOW_THRESH);
    localparam logic [7:0]    HIGH_LVL = 8'(HIGH_THRESH);
    localparam logic [7:0]    PCT_MAX  = 8'd100;

    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] pre_nxt;
    logic          tick_q;
    logic          eval_q;

    logic [EW-1:0] err_cnt;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nxt;
    logic [7:0]    last_sample;
    logic [7:0]    filtered_q;
    logic          filtered_valid;
    logic          alarm_low_q;
    logic          alarm_high_q;
    logic          err_sample;

    state_t        state_q;
    state_t        state_nxt;
    logic [1:0]    code_q;
    logic [1:0]    code_nxt;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_nxt;
    logic          clr_req;
    logic          clr_seen;
    logic          fault_cond;
    logic          pump_q;
    logic          fault_q;

    // Prescaler; sample_tick is registered from the next count so it never glitches.
    always_comb begin
        pre_nxt = pre_cnt + PW'(1);
        if (pre_cnt == DIV_LAST) begin
            pre_nxt = '0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
            eval_q  <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            tick_q  <= (pre_nxt == DIV_LAST);
            eval_q  <= tick_q;
        end
    end

    assign err_sample = bus.level_error || (bus.level_pct > PCT_MAX);

    always_comb begin
        stable_nxt = SW'(1);
        if ((bus.level_pct == last_sample) && (stable_cnt != '0)) begin
            stable_nxt = (stable_cnt == STB_MAX) ? STB_MAX : stable_cnt + SW'(1);
        end
    end

    // A new sample that completes the run is also the accepted level, so the
    // filtered value and alarms are loaded straight from the input.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt        <= '0;
            stable_cnt     <= '0;
            last_sample    <= '0;
            filtered_q     <= '0;
            filtered_valid <= 1'b0;
            alarm_low_q    <= 1'b0;
            alarm_high_q   <= 1'b0;
        end else if (tick_q) begin
            if (err_sample) begin
                if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + EW'(1);
                end
                stable_cnt <= '0;
            end else begin
                err_cnt     <= '0;
                last_sample <= bus.level_pct;
                stable_cnt  <= stable_nxt;
                if (stable_nxt == STB_MAX) begin
                    filtered_q     <= bus.level_pct;
                    filtered_valid <= 1'b1;
                    alarm_low_q    <= (bus.level_pct <= LOW_LVL);
                    alarm_high_q   <= (bus.level_pct >= HIGH_LVL);
                end
            end
        end
    end

    // A clear pulse landing in the eval cycle itself is honoured, then dropped.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            clr_req <= 1'b0;
        end else if (eval_q) begin
            clr_req <= 1'b0;
        end else if (bus.fault_clear) begin
            clr_req <= 1'b1;
        end
    end

    assign clr_seen   = clr_req || bus.fault_clear;
    assign fault_cond = (err_cnt == ERR_MAX);

    always_comb begin
        state_nxt = state_q;
        code_nxt  = code_q;
        run_nxt   = run_cnt;
        if (eval_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fault_cond) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = 2'b01;
                    end else if (filtered_valid && !bus.manual_stop &&
                                 (filtered_q <= LOW_LVL)) begin
                        state_nxt = ST_FILLING;
                        run_nxt   = '0;
                    end
                end
                ST_FILLING: begin
                    if (fault_cond) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = 2'b01;
                    end else if (filtered_q >= HIGH_LVL) begin
                        state_nxt = ST_IDLE;
                    end else if (bus.manual_stop) begin
                        state_nxt = ST_IDLE;
                    end else if (run_cnt == RUN_LAST) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = 2'b10;
                    end else begin
                        run_nxt = run_cnt + RW'(1);
                    end
                end
                ST_FAULT: begin
                    if (!fault_cond && clr_seen && (err_cnt == '0)) begin
                        state_nxt = ST_IDLE;
                        code_nxt  = 2'b00;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    code_nxt  = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            code_q  <= 2'b00;
            run_cnt <= '0;
            pump_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            code_q  <= code_nxt;
            run_cnt <= run_nxt;
            pump_q  <= (state_nxt == ST_FILLING);
            fault_q <= (state_nxt == ST_FAULT);
        end
    end

    assign bus.pump_on        = pump_q;
    assign bus.alarm_low      = alarm_low_q;
    assign bus.alarm_high     = alarm_high_q;
    assign bus.fault          = fault_q;
    assign bus.fault_code     = code_q;
    assign bus.state          = state_q;
    assign bus.filtered_level = filtered_q;
    assign bus.sample_tick    = tick_q;

endmodule

// File: tb/tb_level_pump_controller.sv
// Scoreboard bench for level_pump_controller: one expected output word per sample
// period from a history-based reference model, checked two cycles after each tick.
`timescale 1ns/1ps
module tb_level_pump_controller;

    localparam int SAMPLE_DIV     = 4;
    localparam int STABLE_SAMPLES = 3;
    localparam int ERR_SAMPLES    = 2;
    localparam int LOW_THRESH     = 25;
    localparam int HIGH_THRESH    = 88;
    localparam int PUMP_TIMEOUT   = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    level_pump_controller_if bus();

    level_pump_controller #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .STABLE_SAMPLES(STABLE_SAMPLES),
        .ERR_SAMPLES   (ERR_SAMPLES),
        .LOW_THRESH    (LOW_THRESH),
        .HIGH_THRESH   (HIGH_THRESH),
        .PUMP_TIMEOUT  (PUMP_TIMEOUT)
    ) dut (
        .clk_100MHz(clk),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Reference model: sample history (-1 marks an error sample) plus pump state.
    int hist[$];
    int m_state;
    int m_code;
    int m_fill;
    int m_filt;
    bit m_valid;
    bit m_alow;
    bit m_ahigh;

    function automatic bit tail_all(input int n, input int v);
        if (hist.size() < n) return 1'b0;
        for (int i = hist.size() - n; i < hist.size(); i++) begin
            if (hist[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0; m_code = 0; m_fill = 0; m_filt = 0;
        m_valid = 1'b0; m_alow = 1'b0; m_ahigh = 1'b0;
    endtask

    task automatic model_period(input int lvl, input bit err, input bit ms, input bit clr);
        int  s;
        bit  sensor_fault;
        bit  sensor_ok;
        s = (err || lvl > 100) ? -1 : lvl;
        hist.push_back(s);
        if (hist.size() > 16) void'(hist.pop_front());
        if (s >= 0 && tail_all(STABLE_SAMPLES, s)) begin
            m_filt  = s;
            m_valid = 1'b1;
            m_alow  = (s <= LOW_THRESH);
            m_ahigh = (s >= HIGH_THRESH);
        end
        sensor_fault = tail_all(ERR_SAMPLES, -1);
        sensor_ok    = (s >= 0);
        case (m_state)
            0: begin
                if (sensor_fault) begin
                    m_state = 2; m_code = 1;
                end else if (m_valid && !ms && m_filt <= LOW_THRESH) begin
                    m_state = 1; m_fill = 0;
                end
            end
            1: begin
                if (sensor_fault) begin
                    m_state = 2; m_code = 1;
                end else if (m_filt >= HIGH_THRESH || ms) begin
                    m_state = 0;
                end else if (m_fill == PUMP_TIMEOUT - 1) begin
                    m_state = 2; m_code = 2;
                end else begin
                    m_fill++;
                end
            end
            default: begin
                if (!sensor_fault && clr && sensor_ok) begin
                    m_state = 0; m_code = 0;
                end
            end
        endcase
    endtask

    function automatic logic [15:0] model_word();
        return {(m_state == 1), m_alow, m_ahigh, (m_state == 2),
                2'(m_code), 2'(m_state), 8'(m_filt)};
    endfunction

    function automatic logic [15:0] dut_word();
        return {bus.pump_on, bus.alarm_low, bus.alarm_high, bus.fault,
                bus.fault_code, bus.state, bus.filtered_level};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < 16);
        if (!bus.sample_tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=no_tick required=tick within %0d cycles", n);
        end
    endtask

    // Inputs change two cycles after a tick and hold through the next tick and eval.
    task automatic run_period(input int lvl, input bit err, input bit ms, input bit clr);
        bus.level_pct   = 8'(lvl);
        bus.level_error = err;
        bus.manual_stop = ms;
        bus.fault_clear = clr;
        model_period(lvl, err, ms, clr);
        exp_q.push_back(model_word());
        if (clr) begin
            @(negedge clk);
            bus.fault_clear = 1'b0;
        end
        wait_tick();
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: every tick opens one output window two cycles later.
    initial begin
        int prev;
        prev = -1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = -1;
            end else if (bus.sample_tick) begin
                if (prev >= 0) check("tick_interval", 16'(cyc - prev), 16'(SAMPLE_DIV));
                prev = cyc;
                @(negedge clk);
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL period actual=%h required=none_pending", dut_word());
                end else begin
                    check("period", dut_word(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lvl;
        int hold;
        int r;
        bus.level_pct   = 8'd0;
        bus.level_error = 1'b0;
        bus.manual_stop = 1'b0;
        bus.fault_clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", dut_word(), model_word());
        check("reset_tick", 16'(bus.sample_tick), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Low level starts the pump, high level stops it, alternating never settles.
        repeat (4) run_period(12, 1'b0, 1'b0, 1'b0);
        repeat (4) run_period(100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_period((i % 2 == 0) ? 50 : 63, 1'b0, 1'b0, 1'b0);

        // Sensor fault while filling, clear ignored during error, then honoured.
        repeat (3) run_period(12, 1'b0, 1'b0, 1'b0);
        repeat (2) run_period(12, 1'b1, 1'b0, 1'b0);
        run_period(12, 1'b1, 1'b0, 1'b1);
        run_period(12, 1'b0, 1'b0, 1'b1);

        // Pump timeout, then recovery back into filling.
        repeat (7) run_period(12, 1'b0, 1'b0, 1'b0);
        run_period(12, 1'b0, 1'b0, 1'b1);
        repeat (2) run_period(12, 1'b0, 1'b0, 1'b0);

        // Manual stop inhibits filling until released.
        repeat (2) run_period(12, 1'b0, 1'b1, 1'b0);
        run_period(12, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between clock edges while filling.
        #1;
        check("pre_reset_pump", 16'(bus.pump_on), 16'(m_state == 1));
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_word(), model_word());
        check("async_reset_tick", 16'(bus.sample_tick), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) run_period(12, 1'b0, 1'b0, 1'b0);

        // Randomised bursts of held levels, errors, stops and clears.
        lvl  = 0;
        hold = 0;
        for (int p = 0; p < 250; p++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r <= 2)      lvl = $urandom_range(0, 25);
                else if (r <= 5) lvl = $urandom_range(88, 100);
                else if (r <= 8) lvl = $urandom_range(26, 87);
                else             lvl = $urandom_range(101, 255);
                hold = $urandom_range(1, 5);
            end
            hold--;
            run_period(lvl, ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0));
        end

        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
